// File: rtl/seg_scan_decoder_pkg.sv
// seg_scan_decoder_pkg: shared types and constants for the scanned
// seven-segment capture block. Segment codes are active-low {g,f,e,d,c,b,a}.
package seg_scan_decoder_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b0000011;
   localparam logic [6:0] SEG_C     = 7'b1000110;
   localparam logic [6:0] SEG_D     = 7'b0100001;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_F     = 7'b0001110;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Result of decoding one segment pattern.
   typedef struct packed {
      logic       ok;
      logic       blank;
      logic [3:0] nibble;
   } hex_dec_t;

   // TRACK: counting identical samples; HOLD: pattern accepted, waiting for a change.
   typedef enum logic {
      TRACK = 1'b0,
      HOLD  = 1'b1
   } state_e;

   // Number of active (low) anodes in a 4-bit anode vector.
   function automatic logic [2:0] count_low(input logic [3:0] v);
      logic [2:0] c;
      c = 3'd0;
      for (int i = 0; i < 4; i++) begin
         c = c + {2'b00, ~v[i]};
      end
      return c;
   endfunction

endpackage

// File: rtl/seg_scan_decoder_seg7_to_hex.sv
// seg7_to_hex: combinational lookup of an active-low seven-segment pattern
// into a hex nibble, with legal-decode and blank flags.
module seg7_to_hex
   import seg_scan_decoder_pkg::*;
(
   input  logic [6:0] seg_i,
   output hex_dec_t   dec_o
);

   // Table lookup; anything outside 0-F and blank decodes as nibble 0, not ok.
   always_comb begin
      dec_o = '{ok: 1'b1, blank: 1'b0, nibble: 4'h0};
      case (seg_i)
         SEG_0:     dec_o.nibble = 4'h0;
         SEG_1:     dec_o.nibble = 4'h1;
         SEG_2:     dec_o.nibble = 4'h2;
         SEG_3:     dec_o.nibble = 4'h3;
         SEG_4:     dec_o.nibble = 4'h4;
         SEG_5:     dec_o.nibble = 4'h5;
         SEG_6:     dec_o.nibble = 4'h6;
         SEG_7:     dec_o.nibble = 4'h7;
         SEG_8:     dec_o.nibble = 4'h8;
         SEG_9:     dec_o.nibble = 4'h9;
         SEG_A:     dec_o.nibble = 4'hA;
         SEG_B:     dec_o.nibble = 4'hB;
         SEG_C:     dec_o.nibble = 4'hC;
         SEG_D:     dec_o.nibble = 4'hD;
         SEG_E:     dec_o.nibble = 4'hE;
         SEG_F:     dec_o.nibble = 4'hF;
         SEG_BLANK: dec_o = '{ok: 1'b0, blank: 1'b1, nibble: 4'h0};
         default:   dec_o = '{ok: 1'b0, blank: 1'b0, nibble: 4'h0};
      endcase
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: samples a multiplexed 4-digit active-low anode/segment
// bus, accepts a pattern after STABLE_CYCLES identical samples, decodes it and
// stores it per digit. Flags multi-anode patterns, frame completion and a
// dark display. Define SEG_SCAN_SYNC_EN to insert a 2-flop input synchronizer.
// Handshake: there is none; sample_en is a plain qualifier and every sampled
// value is consumed, new_digit/frame_done are single-cycle pulses.
module seg_scan_decoder
   import seg_scan_decoder_pkg::*;
#(
   parameter int STABLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 1024
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sample_en,
   input  logic [3:0]  anode_in,
   input  logic [6:0]  seg_in,
   input  logic        clear,
   output logic [15:0] digit_val,
   output logic [3:0]  digit_ok,
   output logic [3:0]  digit_blank,
   output logic        new_digit,
   output logic [1:0]  digit_idx,
   output logic        frame_done,
   output logic        dark,
   output logic        err_multi,
   output state_e      dbg_state_o
);

   localparam int SW = $clog2(STABLE_CYCLES + 1);
   localparam int DW = $clog2(TIMEOUT_CYCLES + 1);

   logic [10:0] pat_s;

`ifdef SEG_SCAN_SYNC_EN
   logic [10:0] sync1_q, sync2_q;
   // Two-flop synchronizer; idles at all-ones (display dark, segments off).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '1;
         sync2_q <= '1;
      end else begin
         sync1_q <= {anode_in, seg_in};
         sync2_q <= sync1_q;
      end
   end
   assign pat_s = sync2_q;
`else
   assign pat_s = {anode_in, seg_in};
`endif

   logic [3:0]    anode_s;
   logic [10:0]   prev_q;
   logic          armed_q;
   logic [SW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] dcnt_q;
   state_e        state_q;
   logic [3:0]    mask_q, mask_d;
   logic          same_s, accept_s, capture_s, one_low_s;
   logic [1:0]    idx_s;
   hex_dec_t      dec_s;

   logic [15:0] digit_val_q;
   logic [3:0]  digit_ok_q, digit_blank_q;
   logic        new_digit_q, frame_done_q, dark_q, err_multi_q;
   logic [1:0]  digit_idx_q;

   assign anode_s = pat_s[10:7];

   seg7_to_hex u_dec (
      .seg_i (pat_s[6:0]),
      .dec_o (dec_s)
   );

   // Stability count, accept decision, digit select and next frame mask.
   always_comb begin
      same_s    = armed_q && (pat_s == prev_q);
      cnt_d     = SW'(1);
      if (same_s) begin
         cnt_d = (cnt_q == SW'(STABLE_CYCLES)) ? cnt_q : cnt_q + SW'(1);
      end
      accept_s  = sample_en && (state_q == TRACK) && (cnt_d == SW'(STABLE_CYCLES));
      one_low_s = 1'b1;
      idx_s     = 2'd0;
      case (anode_s)
         4'b1110: idx_s = 2'd0;
         4'b1101: idx_s = 2'd1;
         4'b1011: idx_s = 2'd2;
         4'b0111: idx_s = 2'd3;
         default: one_low_s = 1'b0;
      endcase
      capture_s = accept_s && one_low_s;
      mask_d    = clear ? 4'h0 : mask_q;
      if (capture_s) begin
         mask_d = mask_d | ~anode_s;
      end
   end

   // Sampler, TRACK/HOLD FSM, digit store, frame and dark tracking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q        <= '0;
         armed_q       <= 1'b0;
         cnt_q         <= '0;
         dcnt_q        <= '0;
         state_q       <= TRACK;
         mask_q        <= 4'h0;
         digit_val_q   <= 16'h0000;
         digit_ok_q    <= 4'h0;
         digit_blank_q <= 4'h0;
         new_digit_q   <= 1'b0;
         digit_idx_q   <= 2'd0;
         frame_done_q  <= 1'b0;
         dark_q        <= 1'b0;
         err_multi_q   <= 1'b0;
      end else begin
         new_digit_q  <= 1'b0;
         frame_done_q <= 1'b0;
         mask_q       <= clear ? 4'h0 : mask_q;
         if (clear) begin
            err_multi_q <= 1'b0;
         end
         if (sample_en) begin
            prev_q  <= pat_s;
            armed_q <= 1'b1;
            cnt_q   <= cnt_d;
            case (state_q)
               TRACK:   if (accept_s) state_q <= HOLD;
               HOLD:    if (!same_s) state_q <= TRACK;
               default: state_q <= TRACK;
            endcase
            if (accept_s && (count_low(anode_s) >= 3'd2)) begin
               err_multi_q <= 1'b1;
            end
            if (capture_s) begin
               digit_val_q[{idx_s, 2'b00} +: 4] <= dec_s.nibble;
               digit_ok_q[idx_s]    <= dec_s.ok;
               digit_blank_q[idx_s] <= dec_s.blank;
               new_digit_q <= 1'b1;
               digit_idx_q <= idx_s;
               dark_q      <= 1'b0;
               dcnt_q      <= '0;
               if (mask_d == 4'hF) begin
                  frame_done_q <= 1'b1;
                  mask_q       <= 4'h0;
               end else begin
                  mask_q <= mask_d;
               end
            end else if (anode_s == 4'hF) begin
               if (dcnt_q != DW'(TIMEOUT_CYCLES)) begin
                  dcnt_q <= dcnt_q + DW'(1);
                  if (dcnt_q + DW'(1) == DW'(TIMEOUT_CYCLES)) begin
                     dark_q <= 1'b1;
                     mask_q <= 4'h0;
                  end
               end
            end else begin
               dcnt_q <= '0;
            end
         end
      end
   end

   assign digit_val   = digit_val_q;
   assign digit_ok    = digit_ok_q;
   assign digit_blank = digit_blank_q;
   assign new_digit   = new_digit_q;
   assign digit_idx   = digit_idx_q;
   assign frame_done  = frame_done_q;
   assign dark        = dark_q;
   assign err_multi   = err_multi_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed scan scenarios plus randomized pattern runs,
// checked every cycle against a run-length based reference model.
module tb_seg_scan_decoder;

   localparam int STABLE  = 4;
   localparam int TIMEOUT = 1024;
`ifdef SEG_SCAN_SYNC_EN
   localparam int LAT = STABLE + 2;
`else
   localparam int LAT = STABLE;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sample_en = 1'b0;
   logic clear = 1'b0;
   logic [3:0] anode_in = 4'hF;
   logic [6:0] seg_in = 7'h7F;
   logic [15:0] digit_val;
   logic [3:0]  digit_ok, digit_blank;
   logic        new_digit, frame_done, dark, err_multi;
   logic [1:0]  digit_idx;
   seg_scan_decoder_pkg::state_e dbg_state;

   always #5 clk = ~clk;

   seg_scan_decoder #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sample_en   (sample_en),
      .anode_in    (anode_in),
      .seg_in      (seg_in),
      .clear       (clear),
      .digit_val   (digit_val),
      .digit_ok    (digit_ok),
      .digit_blank (digit_blank),
      .new_digit   (new_digit),
      .digit_idx   (digit_idx),
      .frame_done  (frame_done),
      .dark        (dark),
      .err_multi   (err_multi),
      .dbg_state_o (dbg_state)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;
   logic [5:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [6:0] seg_tab[16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
   logic [15:0] m_val;
   logic [3:0]  m_ok, m_blank, m_mask;
   logic        m_new, m_frame, m_dark, m_err;
   logic [1:0]  m_idx;
   int          m_run, m_drun;
   bit          m_have;
   logic [10:0] m_prev, m_pipe0, m_pipe1;

   task automatic model_reset();
      m_val = 16'h0; m_ok = 4'h0; m_blank = 4'h0; m_mask = 4'h0;
      m_new = 1'b0; m_frame = 1'b0; m_dark = 1'b0; m_err = 1'b0; m_idx = 2'd0;
      m_run = 0; m_drun = 0; m_have = 1'b0; m_prev = '0;
      m_pipe0 = '1; m_pipe1 = '1;
   endtask

   task automatic model_step(input logic [3:0] a_in, input logic [6:0] s_in,
                             input bit en, input bit clr);
      logic [10:0] pat;
      logic [3:0]  a;
      logic [6:0]  s;
      int          zeros, d;
      logic [3:0]  nib;
      logic        ok;
`ifdef SEG_SCAN_SYNC_EN
      pat = m_pipe1; m_pipe1 = m_pipe0; m_pipe0 = {a_in, s_in};
`else
      pat = {a_in, s_in};
`endif
      a = pat[10:7]; s = pat[6:0];
      m_new = 1'b0; m_frame = 1'b0;
      if (clr) begin m_err = 1'b0; m_mask = 4'h0; end
      if (en) begin
         if (m_have && pat == m_prev) m_run++; else m_run = 1;
         m_have = 1'b1; m_prev = pat;
         if (m_run == STABLE) begin
            zeros = 0; d = 0;
            for (int i = 0; i < 4; i++) if (!a[i]) begin zeros++; d = i; end
            if (zeros >= 2) m_err = 1'b1;
            else if (zeros == 1) begin
               nib = 4'h0; ok = 1'b0;
               for (int k = 0; k < 16; k++) if (s == seg_tab[k]) begin ok = 1'b1; nib = 4'(k); end
               m_val[d*4 +: 4] = nib;
               m_ok[d] = ok;
               m_blank[d] = (s == 7'h7F);
               m_new = 1'b1; m_idx = 2'(d);
               m_dark = 1'b0; m_drun = 0;
               m_mask[d] = 1'b1;
               if (m_mask == 4'hF) begin m_frame = 1'b1; m_mask = 4'h0; end
               exp_q.push_back({2'(d), nib});
            end
         end
         if (a == 4'hF) begin
            m_drun++;
            if (m_drun == TIMEOUT) begin m_dark = 1'b1; m_mask = 4'h0; end
         end else begin
            m_drun = 0;
         end
      end
   endtask

   task automatic compare_all();
      logic [5:0] e;
      check("digit_val", digit_val, m_val);
      check("digit_ok", digit_ok, m_ok);
      check("digit_blank", digit_blank, m_blank);
      check("new_digit", new_digit, m_new);
      check("digit_idx", digit_idx, m_idx);
      check("frame_done", frame_done, m_frame);
      check("dark", dark, m_dark);
      check("err_multi", err_multi, m_err);
      if (new_digit) begin
         if (exp_q.size() == 0) check("sb_unexpected_capture", new_digit, 1'b0);
         else begin
            e = exp_q.pop_front();
            check("sb_capture", {digit_idx, digit_val[{digit_idx, 2'b00} +: 4]}, e);
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step(input logic [3:0] a, input logic [6:0] s, input bit en, input bit clr);
      @(negedge clk);
      anode_in = a; seg_in = s; sample_en = en; clear = clr;
      @(posedge clk);
      model_step(a, s, en, clr);
      #1;
      compare_all();
   endtask

   task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n, output int caps);
      caps = 0;
      for (int i = 0; i < n; i++) begin
         step(a, s, 1'b1, 1'b0);
         if (new_digit) caps++;
      end
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      exp_q.delete();
      compare_all();
      check("reset_state", dbg_state, seg_scan_decoder_pkg::TRACK);
      @(negedge clk);
      sample_en = 1'b0; clear = 1'b0; anode_in = 4'hF; seg_in = 7'h7F;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   int caps, frames, first;
   logic [15:0] saved_val;
   logic [3:0]  pa;
   logic [6:0]  ps;
   int          len;

   initial begin
      model_reset();
      do_reset();

      // Single stable digit: first capture after exactly LAT samples.
      step(4'hF, 7'h7F, 1'b1, 1'b0);
      first = 0; caps = 0;
      for (int i = 1; i <= 10; i++) begin
         step(4'b0111, 7'b0011001, 1'b1, 1'b0);
         if (new_digit) begin caps++; if (first == 0) first = i; end
      end
      check("first_capture_latency", first, LAT);
      check("single_digit_captures", caps, 1);
      check("digit3_value", digit_val[15:12], 4'h4);

      // Full scan frame.
      do_reset();
      frames = 0;
      foreach (seg_tab[k]) begin end
      for (int r = 0; r < 4; r++) begin
         case (r)
            0: begin pa = 4'b0111; ps = 7'b0011001; end
            1: begin pa = 4'b1011; ps = 7'b0000000; end
            2: begin pa = 4'b1101; ps = 7'b0010000; end
            default: begin pa = 4'b1110; ps = 7'b1111001; end
         endcase
         for (int i = 0; i < 8; i++) begin
            step(pa, ps, 1'b1, 1'b0);
            if (frame_done) frames++;
         end
      end
      check("scan_value", digit_val, 16'h4891);
      check("scan_ok", digit_ok, 4'hF);
      check("scan_frames", frames, 1);

      // Short glitch inside a held digit.
      saved_val = digit_val;
      step(4'b1110, 7'b0000000, 1'b1, 1'b0);
      step(4'b1110, 7'b0000000, 1'b1, 1'b0);
      hold(4'b1110, 7'b1111001, LAT - 1, caps);
      check("glitch_no_capture", caps, 0);
      check("glitch_value", digit_val, saved_val);

      // Multi-anode pattern, then clear.
      hold(4'b0011, 7'b0000000, 8, caps);
      check("multi_no_capture", caps, 0);
      check("multi_err", err_multi, 1'b1);
      step(4'b0011, 7'b0000000, 1'b1, 1'b1);
      check("multi_cleared", err_multi, 1'b0);

      // Dark timeout, recovery, blank digit.
      saved_val = digit_val;
      hold(4'hF, 7'h7F, TIMEOUT + 4, caps);
      check("dark_set", dark, 1'b1);
      check("dark_retains_value", digit_val, saved_val);
      hold(4'b1110, 7'b0100100, 8, caps);
      check("dark_cleared", dark, 1'b0);
      hold(4'b1110, 7'b1111111, 8, caps);
      check("blank0", digit_blank[0], 1'b1);
      check("blank0_not_ok", digit_ok[0], 1'b0);

      // Randomized runs with sample_en gaps and occasional clear.
      for (int r = 0; r < 400; r++) begin
         case ($urandom_range(0, 6))
            0: pa = 4'b0111; 1: pa = 4'b1011; 2: pa = 4'b1101; 3: pa = 4'b1110;
            4: pa = 4'hF; 5: pa = 4'b0011; default: pa = 4'($urandom_range(0, 15));
         endcase
         case ($urandom_range(0, 3))
            0: ps = 7'h7F;
            1: ps = 7'($urandom_range(0, 127));
            default: ps = seg_tab[$urandom_range(0, 15)];
         endcase
         len = $urandom_range(1, 8);
         for (int i = 0; i < len; i++) begin
            step(pa, ps, $urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0);
         end
         if (r == 200) do_reset();
      end

      check("exp_q_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side companion to the multiplexed seven-segment driver: samples a scanned 4-digit active-low anode/segment bus (the same pins the display driver produces), waits for each anode/segment pattern to settle, decodes the segment pattern back to a hex nibble and stores it per digit. Used as a loop-back checker on the board and as the capture front-end for a display-scraping test harness. Flags blank, undecodable and multi-anode patterns, completed scan frames and a dark display.

## Interface
- STABLE_CYCLES, 4: consecutive identical samples required before a pattern is accepted (≥2).
- TIMEOUT_CYCLES, 1024: consecutive all-anodes-off samples before `dark` asserts (≥1).
- clk  in  1  single system clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- sample_en  in  1  sample strobe; logic advances only when high.
- anode_in  in  4  active-low digit enables; bit 3 = leftmost digit 3, bit 0 = digit 0.
- seg_in  in  7  active-low segments {g,f,e,d,c,b,a}.
- clear  in  1  synchronous clear of `err_multi` and the frame mask.
- digit_val  out  16  nibble i at [4i+3:4i]; reset 16'h0000.
- digit_ok  out  4  digit i holds a legal hex decode; reset 0.
- digit_blank  out  4  digit i last captured as 7'b1111111; reset 0.
- new_digit  out  1  one-cycle pulse per capture; reset 0.
- digit_idx  out  2  index of last capture, valid with `new_digit`; reset 0.
- frame_done  out  1  one-cycle pulse when all four digits captured since last frame; reset 0.
- dark  out  1  display dark (timeout); reset 0.
- err_multi  out  1  sticky: a stable pattern had more than one anode low; reset 0.

## Operation
- Sampled pattern P = {anode, seg}. On each sample, P == previous P: stability counter increments (saturating); else counter = 1 and `armed` is set.
- FSM states: TRACK (counting), HOLD (pattern accepted, wait for change). TRACK→HOLD when counter reaches STABLE_CYCLES; HOLD→TRACK on any change of P. Exactly one accept per stable run.
- On accept, by anode: exactly one zero → capture into that digit; 4'b1111 → no capture; ≥2 zeros → no capture, set `err_multi`.
- Capture: `new_digit`=1, `digit_idx` = digit; segment table (active-low {g..a}) 0:1000000 1:1111001 2:0100100 3:0110000 4:0011001 5:0010010 6:0000010 7:1111000 8:0000000 9:0010000 A:0001000 b:0000011 C:1000110 d:0100001 E:0000110 F:0001110 → nibble, ok=1, blank=0. 1111111 → nibble 0, ok=0, blank=1. Any other pattern → nibble 0, ok=0, blank=0.
- Frame mask ORs in each captured digit; when mask becomes 4'b1111, `frame_done` pulses in the same cycle as that `new_digit`, mask cleared. Re-capturing a digit already in the mask is allowed and does not complete a frame.
- Dark counter counts consecutive samples with anode 4'b1111; at TIMEOUT_CYCLES `dark`=1 and frame mask cleared; `digit_val`/`ok`/`blank` retained. Any capture clears `dark` and the counter.
- `clear` and a capture in the same cycle: mask = captured digit only; `err_multi` cleared unless set by the same accept (set wins).

## Timing
- With sample_en held high and no synchronizer: P changes into the sampler at cycle t; outputs update at the edge ending cycle t+STABLE_CYCLES−1, visible in cycle t+STABLE_CYCLES.
- Glitch shorter than STABLE_CYCLES samples: no capture, no state change to outputs.
- sample_en low: all counters and outputs hold; pulses last exactly one clk cycle regardless of sample_en.
- rst_n low mid-operation: all outputs and counters to reset values immediately; FSM to TRACK with counter 0.

## Configuration
- SEG_SCAN_SYNC_EN defined: anode_in/seg_in pass through a 2-flop synchronizer (reset value all-ones) before sampling; all latencies +2 cycles.
- Undefined: inputs sampled directly (for on-chip loop-back on the same clock).

## Structure
- Shared package: segment code constants for 0–F and blank, decoded nibble type, STATE enum {TRACK, HOLD}.
- Sub-module `seg7_to_hex`: combinational 7-bit → {ok, blank, nibble[3:0]} lookup.

## Test plan
- Stable anode 4'b0111, seg 7'b0011001 for 10 samples → one `new_digit`, idx 3, digit_val[15:12]=4, ok[3]=1, at cycle 4.
- Scan 0111/0011001, 1011/0000000, 1101/0010000, 1110/1111001, 8 samples each → digit_val 16'h4891, digit_ok 4'hF, `frame_done` on the 4th capture only.
- 2-sample glitch of seg 7'b0000000 inside a stable digit → no extra `new_digit`, value unchanged.
- Anode 4'b0011 stable → `err_multi`=1, no capture; `clear` → `err_multi`=0.
- Anode 4'b1111 for 1024 samples → `dark`=1 with digit_val retained; next valid capture → `dark`=0; seg 7'b1111111 on digit 0 → blank[0]=1, ok[0]=0.
